// File: rtl/caravel_fpga_pkg.sv
// rtl/caravel_fpga_pkg.sv - register map, status/ctrl bit indices and FSM states for the ccff loader
package caravel_fpga_pkg;

    localparam int WORD_W_DEF = 32;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_BITCNT = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_LSB_FIRST = 2;
    localparam int CTRL_DIV_LSB   = 8;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_DONE      = 3;
    localparam int STAT_UNDERRUN  = 4;
    localparam int STAT_OVERFLOW  = 5;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_DONE
    } ccff_state_t;

endpackage

// File: rtl/caravel_fpga_ccff_loader_if.sv
// rtl/caravel_fpga_ccff_loader_if.sv - wishbone slave bundle between the Caravel bus and the ccff loader
interface caravel_fpga_ccff_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/caravel_fpga_word_fifo.sv
// rtl/caravel_fpga_word_fifo.sv - show-ahead synchronous word FIFO with flush and fill level
module caravel_fpga_word_fifo #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WORD_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WORD_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign level    = wptr - rptr;
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/caravel_fpga_ccff_loader.sv
// rtl/caravel_fpga_ccff_loader.sv - wishbone bitstream loader driving prog_clk and ccff heads; CCFF_READBACK_EN adds tail capture
module caravel_fpga_ccff_loader
    import caravel_fpga_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NUM_CHAINS = 1,
    parameter int          WORD_W     = WORD_W_DEF,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DIV_W      = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    caravel_fpga_ccff_loader_if.slave wbs,
    output logic                    prog_clk_o,
    output logic [NUM_CHAINS-1:0]   ccff_head_o,
    input  logic [NUM_CHAINS-1:0]   ccff_tail_i,
    output logic                    busy_o
);
    localparam int BPW = WORD_W / NUM_CHAINS;
    localparam int BW  = $clog2(BPW + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    ccff_state_t       state;
    logic              lsb_first;
    logic [DIV_W-1:0]  div;
    logic [31:0]       bitcnt;
    logic [31:0]       remaining;
    logic [BW-1:0]     bits_left;
    logic [DIV_W-1:0]  div_cnt;
    logic [WORD_W-1:0] shreg;
    logic              done;
    logic              underrun;
    logic              overflow;
    logic [WORD_W-1:0] capture;

    logic              wb_req;
    logic              wr_en;
    logic [1:0]        reg_sel;
    logic              ctrl_wr;
    logic              data_wr;
    logic              start_req;
    logic              abort_req;
    logic [31:0]       rd_data;

    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic              fifo_pop;

    // Only the first cycle of a strobe is served; the registered ack masks the repeat.
    assign wb_req    = wbs.wbs_stb_i && wbs.wbs_cyc_i && !wbs.wbs_ack_o
                       && (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = wbs.wbs_adr_i[3:2];
    assign wr_en     = wb_req && wbs.wbs_we_i && (wbs.wbs_sel_i == 4'hF);
    assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL);
    assign data_wr   = wr_en && (reg_sel == REG_DATA);
    assign start_req = ctrl_wr && wbs.wbs_dat_i[CTRL_START];
    assign abort_req = ctrl_wr && wbs.wbs_dat_i[CTRL_ABORT];
    assign fifo_pop  = (state == S_LOAD) && !fifo_empty && !abort_req;

    function automatic logic [NUM_CHAINS-1:0] head_bits(input logic [WORD_W-1:0] w, input logic lsb);
        return lsb ? w[NUM_CHAINS-1:0] : w[WORD_W-1 -: NUM_CHAINS];
    endfunction

    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w, input logic lsb);
        return lsb ? (w >> NUM_CHAINS) : (w << NUM_CHAINS);
    endfunction

    caravel_fpga_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .push      (data_wr),
        .push_data (wbs.wbs_dat_i[WORD_W-1:0]),
        .pop       (fifo_pop),
        .flush     (abort_req),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_LSB_FIRST]         = lsb_first;
                rd_data[CTRL_DIV_LSB +: DIV_W]  = div;
            end
            REG_STATUS: begin
                rd_data[STAT_BUSY]              = busy_o;
                rd_data[STAT_FULL]              = fifo_full;
                rd_data[STAT_EMPTY]             = fifo_empty;
                rd_data[STAT_DONE]              = done;
                rd_data[STAT_UNDERRUN]          = underrun;
                rd_data[STAT_OVERFLOW]          = overflow;
                rd_data[STAT_LEVEL_LSB +: LW]   = fifo_level;
            end
`ifdef CCFF_READBACK_EN
            REG_DATA:   rd_data[WORD_W-1:0] = capture;
`else
            REG_DATA:   rd_data = '0;
`endif
            default:    rd_data = bitcnt;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            lsb_first     <= 1'b0;
            div           <= '0;
            bitcnt        <= '0;
        end else begin
            wbs.wbs_ack_o <= wb_req;
            wbs.wbs_dat_o <= (wb_req && !wbs.wbs_we_i) ? rd_data : '0;
            if (ctrl_wr) begin
                lsb_first <= wbs.wbs_dat_i[CTRL_LSB_FIRST];
                div       <= wbs.wbs_dat_i[CTRL_DIV_LSB +: DIV_W];
            end
            if (wr_en && (reg_sel == REG_BITCNT)) begin
                bitcnt <= wbs.wbs_dat_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= S_IDLE;
            prog_clk_o  <= 1'b0;
            ccff_head_o <= '0;
            busy_o      <= 1'b0;
            remaining   <= '0;
            bits_left   <= '0;
            div_cnt     <= '0;
            shreg       <= '0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
            capture     <= '0;
        end else if (abort_req) begin
            state      <= S_IDLE;
            prog_clk_o <= 1'b0;
            busy_o     <= 1'b0;
            remaining  <= '0;
            bits_left  <= '0;
            div_cnt    <= '0;
        end else begin
            if (data_wr && fifo_full) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        done      <= 1'b0;
                        underrun  <= 1'b0;
                        overflow  <= 1'b0;
                        capture   <= '0;
                        remaining <= bitcnt;
                        busy_o    <= 1'b1;
                        state     <= (bitcnt == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (fifo_empty) begin
                        underrun <= 1'b1;
                    end else begin
                        ccff_head_o <= head_bits(fifo_rdata, lsb_first);
                        shreg       <= shift_word(fifo_rdata, lsb_first);
                        bits_left   <= BW'(BPW);
                        div_cnt     <= '0;
                        state       <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (div_cnt == div) begin
                        prog_clk_o <= 1'b1;
                        remaining  <= remaining - 32'd1;
                        bits_left  <= bits_left - BW'(1);
                        div_cnt    <= '0;
                        state      <= S_HIGH;
`ifdef CCFF_READBACK_EN
                        capture    <= lsb_first ? {ccff_tail_i[0], capture[WORD_W-1:1]}
                                                : {capture[WORD_W-2:0], ccff_tail_i[0]};
`endif
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (div_cnt == div) begin
                        prog_clk_o <= 1'b0;
                        div_cnt    <= '0;
                        if (remaining == '0) begin
                            state <= S_DONE;
                        end else if (bits_left == '0) begin
                            state <= S_LOAD;
                        end else begin
                            ccff_head_o <= head_bits(shreg, lsb_first);
                            shreg       <= shift_word(shreg, lsb_first);
                            state       <= S_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    done   <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], ccff_tail_i};

endmodule
